// File: rtl/e203_exu_flush_sched.sv
// EXU flush scheduler: arbitrates branch-resolve and exception flushes onto the
// single IFU flush port, computes branch targets in a registered add stage.
module e203_exu_flush_sched #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               brch_req_i,
  input  logic [PC_SIZE-1:0] brch_op1_i,
  input  logic [PC_SIZE-1:0] brch_op2_i,
  input  logic [1:0]         brch_kind_i,
  output logic               brch_ack_o,
  input  logic               excp_req_i,
  input  logic [PC_SIZE-1:0] excp_pc_i,
  output logic               excp_ack_o,
  output logic               ifu_flush_req_o,
  output logic [PC_SIZE-1:0] ifu_flush_pc_o,
  output logic               ifu_flush_src_o,
  input  logic               ifu_flush_ack_i,
  output logic               cmt_mret_ena_o,
  output logic               cmt_dret_ena_o,
  output logic               cmt_fencei_ena_o,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   brch_flush_cnt_o,
  output logic [CNT_W-1:0]   excp_flush_cnt_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0]       KIND_FENCEI = 2'd1;
  localparam logic [1:0]       KIND_MRET   = 2'd2;
  localparam logic [1:0]       KIND_DRET   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [PC_SIZE-1:0] op1_q, op1_d;
  logic [PC_SIZE-1:0] op2_q, op2_d;
  logic [1:0]         kind_q, kind_d;
  logic               src_q, src_d;
  logic [CNT_W-1:0]   brch_cnt_q, brch_cnt_d;
  logic [CNT_W-1:0]   excp_cnt_q, excp_cnt_d;

  logic               hs_s;
  logic               brch_hs_s;
  logic               excp_hs_s;
  logic [PC_SIZE-1:0] tgt_sum_s;

  // Handshake is suppressed while reset is asserted so a reset mid-REQ never acks.
  assign hs_s      = (state_q == ST_REQ) & ifu_flush_ack_i & ~rst;
  assign brch_hs_s = hs_s & ~src_q;
  assign excp_hs_s = hs_s &  src_q;
  assign tgt_sum_s = op1_q + op2_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    kind_d  = kind_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (excp_req_i) begin
          pc_d    = excp_pc_i;
          src_d   = 1'b1;
          state_d = ST_REQ;
        end else if (brch_req_i) begin
          op1_d   = brch_op1_i;
          op2_d   = brch_op2_i;
          kind_d  = brch_kind_i;
          src_d   = 1'b0;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // An exception arriving during the add stage kills the branch outright.
        if (excp_req_i) begin
          pc_d  = excp_pc_i;
          src_d = 1'b1;
        end else begin
          pc_d  = tgt_sum_s;
        end
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ifu_flush_ack_i) begin
          state_d = ST_DRAIN;
        end else if (excp_req_i && !src_q) begin
          pc_d  = excp_pc_i;
          src_d = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    brch_cnt_d = brch_cnt_q;
    excp_cnt_d = excp_cnt_q;
    if (cnt_clr_i) begin
      brch_cnt_d = '0;
      excp_cnt_d = '0;
    end else begin
      if (brch_hs_s && (brch_cnt_q != CNT_MAX)) begin
        brch_cnt_d = brch_cnt_q + CNT_ONE;
      end
      if (excp_hs_s && (excp_cnt_q != CNT_MAX)) begin
        excp_cnt_d = excp_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      kind_q     <= 2'd0;
      src_q      <= 1'b0;
      brch_cnt_q <= '0;
      excp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      kind_q     <= kind_d;
      src_q      <= src_d;
      brch_cnt_q <= brch_cnt_d;
      excp_cnt_q <= excp_cnt_d;
    end
  end

  assign ifu_flush_req_o  = (state_q == ST_REQ);
  assign ifu_flush_pc_o   = pc_q;
  assign ifu_flush_src_o  = src_q;
  assign brch_ack_o       = brch_hs_s;
  assign excp_ack_o       = excp_hs_s;
  assign cmt_fencei_ena_o = brch_hs_s & (kind_q == KIND_FENCEI);
  assign cmt_mret_ena_o   = brch_hs_s & (kind_q == KIND_MRET);
  assign cmt_dret_ena_o   = brch_hs_s & (kind_q == KIND_DRET);
  assign brch_flush_cnt_o = brch_cnt_q;
  assign excp_flush_cnt_o = excp_cnt_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
// Directed bench for e203_exu_flush_sched; a narrow counter width keeps the
// saturation scenario short.
module tb_e203_exu_flush_sched;

  localparam int PC_SIZE = 32;
  localparam int CNT_W   = 6;

  logic               clk;
  logic               rst;
  logic               brch_req_i;
  logic [PC_SIZE-1:0] brch_op1_i;
  logic [PC_SIZE-1:0] brch_op2_i;
  logic [1:0]         brch_kind_i;
  logic               brch_ack_o;
  logic               excp_req_i;
  logic [PC_SIZE-1:0] excp_pc_i;
  logic               excp_ack_o;
  logic               ifu_flush_req_o;
  logic [PC_SIZE-1:0] ifu_flush_pc_o;
  logic               ifu_flush_src_o;
  logic               ifu_flush_ack_i;
  logic               cmt_mret_ena_o;
  logic               cmt_dret_ena_o;
  logic               cmt_fencei_ena_o;
  logic               cnt_clr_i;
  logic [CNT_W-1:0]   brch_flush_cnt_o;
  logic [CNT_W-1:0]   excp_flush_cnt_o;
  logic               busy_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_brch_cnt = 0;
  int exp_excp_cnt = 0;

  e203_exu_flush_sched #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .brch_req_i(brch_req_i), .brch_op1_i(brch_op1_i), .brch_op2_i(brch_op2_i),
    .brch_kind_i(brch_kind_i), .brch_ack_o(brch_ack_o),
    .excp_req_i(excp_req_i), .excp_pc_i(excp_pc_i), .excp_ack_o(excp_ack_o),
    .ifu_flush_req_o(ifu_flush_req_o), .ifu_flush_pc_o(ifu_flush_pc_o),
    .ifu_flush_src_o(ifu_flush_src_o), .ifu_flush_ack_i(ifu_flush_ack_i),
    .cmt_mret_ena_o(cmt_mret_ena_o), .cmt_dret_ena_o(cmt_dret_ena_o),
    .cmt_fencei_ena_o(cmt_fencei_ena_o), .cnt_clr_i(cnt_clr_i),
    .brch_flush_cnt_o(brch_flush_cnt_o), .excp_flush_cnt_o(excp_flush_cnt_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run 2 units later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_cnts(input string tag);
    chk_eq({tag, "_bcnt"}, 64'(brch_flush_cnt_o), 64'(exp_brch_cnt));
    chk_eq({tag, "_ecnt"}, 64'(excp_flush_cnt_o), 64'(exp_excp_cnt));
  endtask

  task automatic run_brch(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] kind, input int ack_dly, input logic [31:0] exp_pc);
    brch_req_i = 1'b1; brch_op1_i = op1; brch_op2_i = op2; brch_kind_i = kind;
    next_cyc();
    settle();
    chk_eq({tag, "_calc_busy"}, 64'(busy_o), 64'd1);
    chk_eq({tag, "_calc_req"}, 64'(ifu_flush_req_o), 64'd0);
    next_cyc();
    for (int d = 0; d <= ack_dly; d++) begin
      ifu_flush_ack_i = (d == ack_dly);
      settle();
      chk_eq({tag, "_req"}, 64'(ifu_flush_req_o), 64'd1);
      chk_eq({tag, "_pc"}, 64'(ifu_flush_pc_o), 64'(exp_pc));
      chk_eq({tag, "_src"}, 64'(ifu_flush_src_o), 64'd0);
      chk_eq({tag, "_back"}, 64'(brch_ack_o), 64'(d == ack_dly));
      chk_eq({tag, "_eack"}, 64'(excp_ack_o), 64'd0);
      chk_eq({tag, "_fencei"}, 64'(cmt_fencei_ena_o), 64'((d == ack_dly) && (kind == 2'd1)));
      chk_eq({tag, "_mret"}, 64'(cmt_mret_ena_o), 64'((d == ack_dly) && (kind == 2'd2)));
      chk_eq({tag, "_dret"}, 64'(cmt_dret_ena_o), 64'((d == ack_dly) && (kind == 2'd3)));
      next_cyc();
    end
    brch_req_i = 1'b0; ifu_flush_ack_i = 1'b0;
    if (exp_brch_cnt < (1 << CNT_W) - 1) exp_brch_cnt++;
    settle();
    chk_eq({tag, "_drain_req"}, 64'(ifu_flush_req_o), 64'd0);
    chk_eq({tag, "_drain_busy"}, 64'(busy_o), 64'd1);
    chk_cnts(tag);
    next_cyc();
    settle();
    chk_eq({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_excp(input string tag, input logic [31:0] pc, input int ack_dly, input logic clr);
    excp_req_i = 1'b1; excp_pc_i = pc;
    next_cyc();
    for (int d = 0; d <= ack_dly; d++) begin
      ifu_flush_ack_i = (d == ack_dly);
      cnt_clr_i = clr && (d == ack_dly);
      settle();
      chk_eq({tag, "_req"}, 64'(ifu_flush_req_o), 64'd1);
      chk_eq({tag, "_pc"}, 64'(ifu_flush_pc_o), 64'(pc));
      chk_eq({tag, "_src"}, 64'(ifu_flush_src_o), 64'd1);
      chk_eq({tag, "_eack"}, 64'(excp_ack_o), 64'(d == ack_dly));
      chk_eq({tag, "_back"}, 64'(brch_ack_o), 64'd0);
      next_cyc();
    end
    excp_req_i = 1'b0; ifu_flush_ack_i = 1'b0; cnt_clr_i = 1'b0;
    if (clr) begin
      exp_brch_cnt = 0; exp_excp_cnt = 0;
    end else if (exp_excp_cnt < (1 << CNT_W) - 1) begin
      exp_excp_cnt++;
    end
    settle();
    chk_eq({tag, "_drain_req"}, 64'(ifu_flush_req_o), 64'd0);
    chk_cnts(tag);
    next_cyc();
    settle();
    chk_eq({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; brch_req_i = 1'b0; brch_op1_i = '0; brch_op2_i = '0; brch_kind_i = 2'd0;
    excp_req_i = 1'b0; excp_pc_i = '0; ifu_flush_ack_i = 1'b0; cnt_clr_i = 1'b0;
    repeat (3) next_cyc();
    rst = 1'b0;
    settle();
    chk_eq("rst_req", 64'(ifu_flush_req_o), 64'd0);
    chk_eq("rst_pc", 64'(ifu_flush_pc_o), 64'd0);
    chk_eq("rst_src", 64'(ifu_flush_src_o), 64'd0);
    chk_eq("rst_busy", 64'(busy_o), 64'd0);
    chk_eq("rst_acks", 64'({brch_ack_o, excp_ack_o, cmt_mret_ena_o, cmt_dret_ena_o, cmt_fencei_ena_o}), 64'd0);
    chk_cnts("rst");
    next_cyc();

    run_brch("mispredict", 32'h8000_0100, 32'h0000_0020, 2'd0, 0, 32'h8000_0120);
    run_brch("mret_dly3", 32'h8000_0400, 32'h0000_0000, 2'd2, 3, 32'h8000_0400);
    run_brch("fencei", 32'h8000_0010, 32'h0000_0004, 2'd1, 1, 32'h8000_0014);
    run_brch("dret", 32'h0000_0800, 32'h0000_0000, 2'd3, 0, 32'h0000_0800);
    run_brch("wrap", 32'hFFFF_FFFC, 32'h0000_0004, 2'd0, 0, 32'h0000_0000);
    run_excp("excp_plain", 32'h8000_0080, 2, 1'b0);

    // Both requesters in IDLE: exception first, the held branch afterwards.
    brch_req_i = 1'b1; brch_op1_i = 32'h8000_0200; brch_op2_i = 32'h0000_0008; brch_kind_i = 2'd0;
    run_excp("prio_excp", 32'h8000_0000, 0, 1'b0);
    brch_op1_i = 32'h8000_0200;
    run_brch("prio_brch", 32'h8000_0200, 32'h0000_0008, 2'd0, 0, 32'h8000_0208);

    // Exception during CALC drops the branch.
    brch_req_i = 1'b1; brch_op1_i = 32'h8000_0300; brch_op2_i = 32'h0000_0010; brch_kind_i = 2'd2;
    next_cyc();
    excp_req_i = 1'b1; excp_pc_i = 32'h8000_0040;
    settle();
    chk_eq("calc_pre_back", 64'(brch_ack_o), 64'd0);
    next_cyc();
    brch_req_i = 1'b0; ifu_flush_ack_i = 1'b1;
    settle();
    chk_eq("calc_pre_pc", 64'(ifu_flush_pc_o), 64'h8000_0040);
    chk_eq("calc_pre_src", 64'(ifu_flush_src_o), 64'd1);
    chk_eq("calc_pre_eack", 64'(excp_ack_o), 64'd1);
    chk_eq("calc_pre_back2", 64'(brch_ack_o), 64'd0);
    chk_eq("calc_pre_mret", 64'(cmt_mret_ena_o), 64'd0);
    next_cyc();
    excp_req_i = 1'b0; ifu_flush_ack_i = 1'b0; exp_excp_cnt++;
    settle();
    chk_cnts("calc_pre");
    next_cyc();

    // Exception preempts a branch that is waiting in REQ.
    brch_req_i = 1'b1; brch_op1_i = 32'h8000_1000; brch_op2_i = 32'h0000_0010; brch_kind_i = 2'd0;
    next_cyc();
    next_cyc();
    excp_req_i = 1'b1; excp_pc_i = 32'h8000_2000;
    settle();
    chk_eq("req_pre_pc0", 64'(ifu_flush_pc_o), 64'h8000_1010);
    chk_eq("req_pre_back0", 64'(brch_ack_o), 64'd0);
    next_cyc();
    brch_req_i = 1'b0; ifu_flush_ack_i = 1'b1;
    settle();
    chk_eq("req_pre_req", 64'(ifu_flush_req_o), 64'd1);
    chk_eq("req_pre_pc", 64'(ifu_flush_pc_o), 64'h8000_2000);
    chk_eq("req_pre_src", 64'(ifu_flush_src_o), 64'd1);
    chk_eq("req_pre_eack", 64'(excp_ack_o), 64'd1);
    chk_eq("req_pre_back", 64'(brch_ack_o), 64'd0);
    next_cyc();
    excp_req_i = 1'b0; ifu_flush_ack_i = 1'b0; exp_excp_cnt++;
    settle();
    chk_cnts("req_pre");
    next_cyc();

    // Ack and exception in the same cycle: branch completes, exception follows.
    brch_req_i = 1'b1; brch_op1_i = 32'h8000_3000; brch_op2_i = 32'h0000_0004; brch_kind_i = 2'd0;
    next_cyc();
    next_cyc();
    excp_req_i = 1'b1; excp_pc_i = 32'h8000_4000; ifu_flush_ack_i = 1'b1;
    settle();
    chk_eq("same_back", 64'(brch_ack_o), 64'd1);
    chk_eq("same_eack", 64'(excp_ack_o), 64'd0);
    next_cyc();
    brch_req_i = 1'b0; ifu_flush_ack_i = 1'b0; exp_brch_cnt++;
    settle();
    chk_cnts("same_drain");
    next_cyc();
    run_excp("same_excp", 32'h8000_4000, 0, 1'b0);

    run_excp("clr_hs", 32'h8000_0500, 0, 1'b1);

    // Saturation: 2^CNT_W exception flushes after a clear.
    for (int i = 0; i < (1 << CNT_W); i++) run_excp("sat", 32'h8000_0600, 0, 1'b0);
    chk_eq("sat_final", 64'(excp_flush_cnt_o), 64'((1 << CNT_W) - 1));

    // Reset while a flush is pending in REQ.
    excp_req_i = 1'b1; excp_pc_i = 32'h8000_0700;
    next_cyc();
    excp_req_i = 1'b0; rst = 1'b1;
    settle();
    chk_eq("rstreq_req0", 64'(ifu_flush_req_o), 64'd1);
    chk_eq("rstreq_eack0", 64'(excp_ack_o), 64'd0);
    next_cyc();
    rst = 1'b0; exp_brch_cnt = 0; exp_excp_cnt = 0;
    settle();
    chk_eq("rstreq_req", 64'(ifu_flush_req_o), 64'd0);
    chk_eq("rstreq_busy", 64'(busy_o), 64'd0);
    chk_eq("rstreq_acks", 64'({brch_ack_o, excp_ack_o}), 64'd0);
    chk_cnts("rstreq");
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/e203_exu_flush_sched.md
# e203_exu_flush_sched

Sequential scheduler for the EXU pipeline-flush port toward the IFU. It arbitrates between two requesters: branch-resolve flushes (mispredict, fence.i, mret, dret) and non-ALU exception/IRQ flushes. Branch targets arrive as adder operands, and the block computes them in a registered add stage. It holds each flush on the IFU handshake until acknowledged and keeps saturating flush statistics. It sits between the commit-stage branch-resolve logic / exception unit and the IFU flush interface.

## Interface
- PC_SIZE, 32, width of PC and adder operands
- CNT_W, 16, width of statistic counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- brch_req_i  in  1  branch-class flush request; held until brch_ack_o
- brch_op1_i  in  PC_SIZE  target adder operand 1 (PC, EPC or DPC)
- brch_op2_i  in  PC_SIZE  target adder operand 2 (imm, 2/4 or 0)
- brch_kind_i  in  2  0=bjp, 1=fencei, 2=mret, 3=dret
- brch_ack_o  out  1  one-cycle pulse: branch flush accepted by IFU
- excp_req_i  in  1  exception/IRQ flush request; held until excp_ack_o
- excp_pc_i  in  PC_SIZE  final exception target PC
- excp_ack_o  out  1  one-cycle pulse: exception flush accepted by IFU
- ifu_flush_req_o  out  1  flush request to IFU
- ifu_flush_pc_o  out  PC_SIZE  flush target, registered
- ifu_flush_src_o  out  1  0=branch, 1=exception
- ifu_flush_ack_i  in  1  IFU accepts flush
- cmt_mret_ena_o / cmt_dret_ena_o / cmt_fencei_ena_o  out  1 each  pulse with brch_ack_o when the kind matches
- cnt_clr_i  in  1  clears both counters
- brch_flush_cnt_o  out  CNT_W  completed branch flushes, saturating
- excp_flush_cnt_o  out  CNT_W  completed exception flushes, saturating
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, CALC, REQ, DRAIN. Registers: pc_q, op1_q, op2_q, kind_q, src_q.
- IDLE:
  - If excp_req_i: pc_q<=excp_pc_i, src_q<=1, go to REQ.
  - Else if brch_req_i: op1_q/op2_q/kind_q captured, src_q<=0, go to CALC.
  - Exception has strict priority when both are asserted.
- CALC: pc_q<=op1_q+op2_q, truncated to PC_SIZE (carry dropped, wraps), then go to REQ.
  - If excp_req_i in CALC: preempt. pc_q<=excp_pc_i, src_q<=1, go to REQ. The branch is dropped and no brch_ack_o is issued.
- REQ: ifu_flush_req_o=1, ifu_flush_pc_o=pc_q, ifu_flush_src_o=src_q.
  - On ifu_flush_ack_i: pulse the ack for src_q, plus the kind enable when src_q=0; increment the matching counter; go to DRAIN.
  - If excp_req_i while src_q=0 and no ack this cycle: preempt. pc_q/src_q reloaded, stay in REQ; req remains high with the new PC next cycle.
  - If ack and excp_req_i arrive in the same cycle: the branch completes; the exception is served after DRAIN.
- DRAIN: one cycle, requests ignored, then go to IDLE.
- A branch requester whose flush was preempted must drop brch_req_i (its instruction is killed). All requesters drop req the cycle after their ack.
- Counters: saturate at all-ones; cnt_clr_i has priority over increment.
- ifu_flush_pc_o and ifu_flush_src_o drive pc_q and src_q at all times; they are only meaningful while ifu_flush_req_o is high.

## Timing
- Reset: state IDLE; pc_q, op1_q, op2_q, kind_q, src_q = 0; all outputs 0; counters 0. Reset mid-REQ drops the request in the next cycle with no ack.
- Branch latency: req sampled in cycle 0, CALC in cycle 1, ifu_flush_req_o high in cycle 2.
- Exception latency: req sampled in cycle 0, ifu_flush_req_o high in cycle 1.
- Ack pulses appear in the same cycle as the ifu_flush_req_o & ifu_flush_ack_i handshake.
- Counters update the cycle after the handshake.
- Minimum spacing: branch flushes every 4 cycles, exception flushes every 3.
- No combinational path from request inputs to ifu_flush_* outputs.

## Test plan
- Mispredict: brch op1=0x8000_0100, op2=0x0000_0020, kind=0; IFU ack at first REQ cycle -> ifu_flush_req_o in cycle 2 with pc=0x8000_0120, src=0; brch_ack_o pulse in cycle 2; brch_flush_cnt=1.
- mret, ack delayed 3 cycles: op1=0x8000_0400, op2=0 -> req held 4 cycles with pc stable; cmt_mret_ena_o and brch_ack_o pulse only in the ack cycle.
- Priority and preemption:
  - brch and excp asserted together in IDLE (excp_pc=0x8000_0000) -> src=1 flush first; after DRAIN the branch is served.
  - excp arriving in CALC -> branch dropped, no brch_ack_o.
- Preempt in REQ: branch flush pending without ack, excp_req_i arrives -> next cycle ifu_flush_pc_o=excp_pc, src=1; only excp_ack_o on ack; excp_flush_cnt=1, brch_flush_cnt unchanged.
- Wrap and saturation:
  - op1=0xFFFF_FFFC, op2=4 -> pc=0x0000_0000.
  - Counter preloaded to 0xFFFF by 65535 flushes stays at 0xFFFF.
  - cnt_clr_i coincident with a handshake -> counter reads 0.
- Reset in REQ: assert rst -> next cycle ifu_flush_req_o=0, busy_o=0, counters 0, no ack pulses.
